// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command sequencer driving an 8-bit shift_register's load/shift pins
// Accepts {data, dir, count}, pulses load once, shifts count times, returns sampled sr_out.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             sr_load,
  output logic             sr_shift_en,
  output logic             sr_dir,
  output logic [WIDTH-1:0] sr_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_rsp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_dir       <= 1'b0;
      r_count     <= '0;
      r_remaining <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && cmd_valid) begin
        r_data  <= cmd_data;
        r_dir   <= cmd_dir;
        r_count <= cmd_count;
      end
      // remaining is loaded as a full CNT_W value, so the maximum count never wraps
      if (r_state == S_LOAD) begin
        r_remaining <= r_count;
      end else if (r_state == S_SHIFT) begin
        r_remaining <= r_remaining - ONE;
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_data <= sr_out;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    sr_load     = 1'b0;
    sr_shift_en = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        sr_load = 1'b1;
        w_next  = (r_count == '0) ? S_CAPTURE : S_SHIFT;
      end
      S_SHIFT: begin
        sr_shift_en = 1'b1;
        if (r_remaining == ONE) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign sr_in    = r_data;
  assign sr_dir   = r_dir;
  assign rsp_data = r_rsp_data;
  assign busy     = (r_state != S_IDLE);

endmodule
